// File: rtl/acsi_pkg.sv
// rtl/acsi_pkg.sv - shared register map, control/status bit positions and RX entry layout
package acsi_pkg;

   typedef enum logic [1:0] {
      SEL_DATA = 2'b00,
      SEL_CTRL = 2'b01,
      SEL_IDS  = 2'b10,
      SEL_STAT = 2'b11
   } reg_sel_e;

   localparam int CTL_FLUSH = 0;
   localparam int CTL_CMD   = 5;
   localparam int CTL_UNSEL = 6;
   localparam int CTL_CLR   = 7;

   localparam int ST_TX_UNF   = 0;
   localparam int ST_OVF      = 1;
   localparam int ST_RX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_TX_EMPTY = 4;
   localparam int ST_TX_FULL  = 5;
   localparam int ST_CMD      = 6;
   localparam int ST_SEL      = 7;

   localparam logic [7:0] CTL_RESET = 8'h20;
   // Action bits fire on write and are never held in the control register.
   localparam logic [7:0] CTL_VOLATILE = 8'hC1;

   typedef struct packed {
      logic       first_cmd;
      logic [7:0] data;
   } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with drop-on-full, ignore-on-empty and flush
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic             do_push, do_pop;

   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty = (wr_q == rd_q);

   // A concurrent pop frees the slot a full push needs, and vice versa when empty.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & (~empty | push);

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PTR_ONE;
         if (do_pop)  rd_d = rd_q + PTR_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= din;
   end

   assign dout = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/acsi_fifo_bridge.sv
// rtl/acsi_fifo_bridge.sv - ACSI-to-AVR bridge with RX/TX FIFOs, status register and sticky error flags
module acsi_fifo_bridge
   import acsi_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   inout  wire  [7:0] f_data,
   output logic       f_bus_dir,
   input  logic       f_cs,
   input  logic       f_ack,
   input  logic       f_a1,
   input  logic       f_rw,
   output logic       f_irq,
   output logic       f_drq,
   inout  wire  [7:0] a_data,
   input  logic       a_bus_dir,
   input  logic       a_cs,
   input  logic       a_extra,
   input  logic       a_extra_2,
   input  logic       a_ready,
   output logic       a_int,
   output logic       a_cmd
);

   logic [SYNC_STAGES-1:0] f_cs_sync_q, f_ack_sync_q, a_cs_sync_q;
   logic [1:0]             f_cs_edge_q, f_ack_edge_q, a_cs_edge_q;

   logic       selected_q, selected_d;
   logic [7:0] ctl_q, ctl_d, ids_q, ids_d;
   logic       rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, tx_unf_q, tx_unf_d;

   logic       cs_fall, cs_rise, ack_fall, ack_rise, a_rise;
   logic       cmd_mode, a_wr, a_rd, ctl_wr, ids_wr;
   logic       flush, unsel, clr_flags, first_cmd;
   logic       rx_push, rx_pop, rx_full, rx_empty;
   logic       tx_push, tx_pop, tx_full, tx_empty;
   logic       req;
   rx_entry_t  rx_din, rx_dout;
   logic [7:0] tx_dout, status, rd_mux;
   reg_sel_e   a_sel;

   always_ff @(posedge clock) begin
      if (reset) begin
         f_cs_sync_q  <= '0;
         f_ack_sync_q <= '0;
         a_cs_sync_q  <= '0;
         f_cs_edge_q  <= '0;
         f_ack_edge_q <= '0;
         a_cs_edge_q  <= '0;
      end else begin
         f_cs_sync_q  <= {f_cs_sync_q[SYNC_STAGES-2:0], f_cs};
         f_ack_sync_q <= {f_ack_sync_q[SYNC_STAGES-2:0], f_ack};
         a_cs_sync_q  <= {a_cs_sync_q[SYNC_STAGES-2:0], a_cs};
         f_cs_edge_q  <= {f_cs_edge_q[0], f_cs_sync_q[SYNC_STAGES-1]};
         f_ack_edge_q <= {f_ack_edge_q[0], f_ack_sync_q[SYNC_STAGES-1]};
         a_cs_edge_q  <= {a_cs_edge_q[0], a_cs_sync_q[SYNC_STAGES-1]};
      end
   end

   // Bit 1 is the older sample, bit 0 the newer one.
   assign cs_fall  = (f_cs_edge_q == 2'b10);
   assign cs_rise  = (f_cs_edge_q == 2'b01);
   assign ack_fall = (f_ack_edge_q == 2'b10);
   assign ack_rise = (f_ack_edge_q == 2'b01);
   assign a_rise   = (a_cs_edge_q == 2'b01);

   assign cmd_mode  = ctl_q[CTL_CMD];
   assign a_sel     = reg_sel_e'({a_extra_2, a_extra});
   assign a_wr      = a_rise & a_bus_dir;
   assign a_rd      = a_rise & ~a_bus_dir;
   assign ctl_wr    = a_wr & (a_sel == SEL_CTRL);
   assign ids_wr    = a_wr & (a_sel == SEL_IDS);
   assign flush     = ctl_wr & a_data[CTL_FLUSH];
   assign unsel     = ctl_wr & a_data[CTL_UNSEL];
   assign clr_flags = ctl_wr & a_data[CTL_CLR];

   // The first command byte is queued regardless of selection so the AVR sees all traffic.
   assign first_cmd = cmd_mode & cs_fall & ~f_rw & ~f_a1;
   assign rx_push   = first_cmd |
                      (selected_q & ~f_rw & (cmd_mode ? (cs_fall & f_a1) : ack_fall));
   assign rx_din    = {first_cmd, f_data};
   assign rx_pop    = a_rd & (a_sel == SEL_DATA) & ~rx_empty;
   assign tx_push   = a_wr & (a_sel == SEL_DATA);
   assign tx_pop    = selected_q & f_rw & (cmd_mode ? cs_rise : ack_rise);

   sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .flush (flush),
      .din   (rx_din),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .flush (flush),
      .din   (a_data),
      .dout  (tx_dout),
      .full  (tx_full),
      .empty (tx_empty)
   );

   always_comb begin
      selected_d = selected_q;
      ctl_d      = ctl_q;
      ids_d      = ids_q;
      rx_ovf_d   = rx_ovf_q | (rx_push & rx_full & ~rx_pop & ~flush);
      tx_ovf_d   = tx_ovf_q | (tx_push & tx_full & ~tx_pop & ~flush);
      tx_unf_d   = tx_unf_q | (tx_pop & tx_empty & ~flush);
      if (first_cmd) selected_d = ids_q[f_data[7:5]];
      if (unsel)     selected_d = 1'b0;
      if (ctl_wr)    ctl_d = a_data & ~CTL_VOLATILE;
      if (ids_wr)    ids_d = a_data;
      if (clr_flags) begin
         rx_ovf_d = 1'b0;
         tx_ovf_d = 1'b0;
         tx_unf_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         selected_q <= 1'b0;
         ctl_q      <= CTL_RESET;
         ids_q      <= '0;
         rx_ovf_q   <= 1'b0;
         tx_ovf_q   <= 1'b0;
         tx_unf_q   <= 1'b0;
      end else begin
         selected_q <= selected_d;
         ctl_q      <= ctl_d;
         ids_q      <= ids_d;
         rx_ovf_q   <= rx_ovf_d;
         tx_ovf_q   <= tx_ovf_d;
         tx_unf_q   <= tx_unf_d;
      end
   end

   always_comb begin
      status              = '0;
      status[ST_SEL]      = selected_q;
      status[ST_CMD]      = cmd_mode;
      status[ST_TX_FULL]  = tx_full;
      status[ST_TX_EMPTY] = tx_empty;
      status[ST_RX_FULL]  = rx_full;
      status[ST_RX_EMPTY] = rx_empty;
      status[ST_OVF]      = rx_ovf_q | tx_ovf_q;
      status[ST_TX_UNF]   = tx_unf_q;
   end

   always_comb begin
      rd_mux = rx_dout.data;
      case (a_sel)
         SEL_STAT: rd_mux = status;
         SEL_IDS:  rd_mux = ids_q;
         SEL_CTRL: rd_mux = ctl_q;
         default:  rd_mux = rx_dout.data;
      endcase
   end

   assign req       = (a_ready & ~rx_full) | ~tx_empty;
   assign f_bus_dir = selected_q & f_rw;
   assign f_irq     = selected_q & cmd_mode & req & f_cs;
   assign f_drq     = selected_q & ~cmd_mode & req & f_ack;
   assign a_int     = selected_q & (a_bus_dir ? ~tx_full : ~rx_empty);
   assign a_cmd     = selected_q & ~rx_empty & rx_dout.first_cmd;

   assign f_data = f_bus_dir ? tx_dout : 8'hzz;
   assign a_data = a_bus_dir ? 8'hzz : rd_mux;

endmodule

// File: doc/acsi_fifo_bridge.md
# acsi_fifo_bridge

Parametrised ACSI-to-AVR bridge with FIFOs in both directions. It sits between the Atari ACSI port (`f_*`) and the AVR controller (`a_*`). Command/data phase handling and ACSI-ID selection are unchanged from the single-byte bridge. The single/double byte buffering is replaced by configurable-depth FIFOs, and the bridge adds an AVR-readable status register plus sticky overflow/underrun flags.

## Interface
- `FIFO_DEPTH`, 16: entries per direction; power of two, minimum 2.
- `SYNC_STAGES`, 2: synchroniser flops on `f_cs`, `f_ack`, `a_cs`; minimum 2.
- `clock` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `f_data` inout 8: ACSI data bus.
- `f_bus_dir` out 1: 1 = bridge drives `f_data`.
- `f_cs`, `f_ack`, `f_a1`, `f_rw` in 1 each: ACSI strobes, A1 and read/write (`f_rw` 1 = Atari reads).
- `f_irq`, `f_drq` out 1 each: inverted open-collector drive; 1 = pull line low.
- `a_data` inout 8: AVR data bus.
- `a_bus_dir` in 1: 1 = AVR drives, 0 = bridge drives.
- `a_cs` in 1: AVR strobe; action on rising edge.
- `a_extra`, `a_extra_2` in 1 each: register select `{a_extra_2,a_extra}`.
  - 00 = data FIFO.
  - 01 = control.
  - 10 = ACSI ID bitmap.
  - 11 = status (read-only).
- `a_ready` in 1: AVR wants Atari bytes.
- `a_int` out 1: AVR service request.
- `a_cmd` out 1: RX head is a first command byte.

## Operation
- **Edge detection:** strobes pass through `SYNC_STAGES` flops, then a 2-bit edge detector. `f_data` and `a_data` are sampled unsynchronised in the detection cycle.
- **RX FIFO (Atari→AVR):** 9-bit entries, `{first_cmd, byte}`. Pushes:
  - Command mode, `f_cs` fall, `!f_rw`, `!f_a1`: first = 1. This push happens even when the bridge is unselected.
  - Command mode, selected, `f_cs` fall, `!f_rw`, `f_a1`: first = 0.
  - Data mode, selected, `f_ack` fall, `!f_rw`: first = 0.
- **RX pop:** `a_cs` rise, `a_bus_dir` = 0, select 00, RX not empty.
- **TX FIFO (AVR→Atari):** 8-bit entries.
  - Push on `a_cs` rise, `a_bus_dir` = 1, select 00.
  - Pop, selected and `f_rw` = 1: command mode on `f_cs` rise; data mode on `f_ack` rise.
  - `f_data` shows the TX head whenever `selected & f_rw`.
- **Overflow:** push to a full FIFO discards the byte and sets sticky `rx_ovf` or `tx_ovf`.
- **Underrun:** Atari pop of an empty TX FIFO sets sticky `tx_unf`; the FIFO state does not change.
- **Simultaneous push and pop:** both happen, and the level is unchanged. This applies when full or empty.
- **Selection:** first command byte with `acsi_ids[f_data[7:5]]` set → `selected` = 1; with the bit clear → 0.
- **Control register bits:**
  - Bit 0: flush both FIFOs; the bit is not stored.
  - Bit 5: command mode (1) / data mode (0).
  - Bit 6: unselect; not stored.
  - Bit 7: clear sticky flags; not stored.
  - All other bits are stored and have no effect.
- **Control-write priority:** flush and unselect win over a same-cycle push, pop or select.
- **Status byte:** `{selected, cmd_mode, tx_full, tx_empty, rx_full, rx_empty, ovf_any, tx_unf}`, where `ovf_any` = `rx_ovf | tx_ovf`.
- **AVR read mux (`a_data`, when `a_bus_dir` = 0):**
  - select 11 → status.
  - select 10 → `acsi_ids`.
  - select 01 → control.
  - otherwise → RX head byte.
- **Handshake:** `req` = `(a_ready & !rx_full) | !tx_empty`.
  - `f_irq` = `selected & cmd_mode & req & f_cs`.
  - `f_drq` = `selected & !cmd_mode & req & f_ack`.
- **AVR outputs:**
  - `a_int` = `selected & (a_bus_dir ? !tx_full : !rx_empty)`.
  - `a_cmd` = `selected & !rx_empty & rx_head.first_cmd`.
- **Reset values:** `selected` 0, control 0x20, `acsi_ids` 0, FIFOs empty, sticky flags 0, edge detectors 0. All outputs 0; `f_data` and `a_data` are Z.

## Timing
- Strobe edge to action: `SYNC_STAGES` + 1 cycles.
- FIFO status flags update in the cycle after a push or pop.
- `f_data` changes to the next TX byte one cycle after the pop.
- RX entries are readable one cycle after the push; `a_int` rises on the same cycle.
- `f_irq`, `f_drq`, `a_int`, `a_cmd` and `f_bus_dir` are combinational from registered state plus raw `f_cs`, `f_ack`, `a_bus_dir`.
- Reset mid-transfer: all state returns to reset values at the next clock edge; in-flight bytes are lost.

## Structure
- Package `acsi_pkg`:
  - register select codes;
  - control bit indices (`CTL_FLUSH`=0, `CTL_CMD`=5, `CTL_UNSEL`=6, `CTL_CLR`=7);
  - status bit indices;
  - control reset value 0x20.
- Sub-module `sync_fifo`, parameters `WIDTH` and `DEPTH`:
  - ports: push, pop, flush, din, dout (head), full, empty;
  - drop-on-full behaviour.
- Instantiated twice: RX with `WIDTH` 9, TX with `WIDTH` 8.

## Test plan
- IDs = 0x01. Command 0x08 (ID 0) then bytes 0x12, 0x34:
  - `selected` = 1;
  - AVR reads 0x08 with `a_cmd` = 1, then 0x12 and 0x34 with `a_cmd` = 0;
  - `a_int` stays 1 until RX is empty.
- Command 0x28 (ID 1, not enabled): `selected` → 0; `f_irq` and `f_drq` stay 0.
- Data mode, AVR pushes `FIFO_DEPTH`+1 bytes:
  - `a_int` = 0 at full;
  - extra byte dropped; status `ovf_any` = 1;
  - Atari `f_ack` reads return bytes in order;
  - `f_drq` follows `f_ack` while TX is non-empty.
- Atari reads with TX empty: `tx_unf` set. Control write 0x80 clears it; status returns to `tx_empty` = `rx_empty` = 1.
- Control write 0x41 with both FIFOs holding data:
  - FIFOs empty;
  - `selected` = 0;
  - control readback 0x00 (bits 0 and 6 not stored).
- Assert `reset` mid-stream with 3 bytes queued: next cycle control = 0x20, FIFOs empty, all outputs 0.
